ascon_bdo_byte_packer: RTL

- Downstream consumer of the dual-core ASCON top-level output stream.
- Accepts 32-bit output words with byte-valid masks plus auth/done sideband, and serialises only the valid bytes onto a byte-wide valid/ready stream for a host link (UART/SPI bridge).
- Appends one status byte per message. Reports per-message data length and tag-failure status.

---
 rtl/ascon_pkg.sv | 14 +
 rtl/ascon_byte_pick.sv | 9 +
 rtl/ascon_bdo_byte_packer.sv | 100 ++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared state encoding and status-byte layout for the BDO byte packer
package ascon_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, STATUS, END} pack_state_t;
  localparam logic [3:0] STATUS_HDR  = 4'hA;
  localparam int         ST_AUTH_BIT = 2;
  localparam int         ST_TAG_BIT  = 1;
  localparam int         ST_DONE_BIT = 0;
  function automatic logic [7:0] status_byte(input logic auth, input logic tag, input logic done);
    status_byte = {STATUS_HDR, 4'b0000};
    status_byte[ST_AUTH_BIT] = auth;
    status_byte[ST_TAG_BIT]  = tag;
    status_byte[ST_DONE_BIT] = done;
  endfunction
endpackage

// File: rtl/ascon_byte_pick.sv
// ascon_byte_pick: highest-set-lane priority encoder over a byte-valid mask
module ascon_byte_pick (
  input  logic [3:0] mask,
  output logic [1:0] lane,
  output logic       one_left
);
  assign lane     = mask[3] ? 2'd3 : mask[2] ? 2'd2 : mask[1] ? 2'd1 : 2'd0;
  assign one_left = $onehot(mask);
endmodule

// File: rtl/ascon_bdo_byte_packer.sv
// ascon_bdo_byte_packer: serialises valid bytes of ASCON output words onto a byte stream,
// appending an optional per-message status byte and reporting length / tag failure.
module ascon_bdo_byte_packer
  import ascon_pkg::*;
#(
  parameter bit STATUS_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             bd_valid_i,
  input  logic             bd_last_i,
  input  logic [2:0]       bd_type_i,
  input  logic [3:0]       bd_vld_byte_i,
  input  logic [31:0]      bd_i,
  input  logic             auth_valid_i,
  input  logic             tag_match_i,
  input  logic             done_i,
  output logic             bdo_ready_o,
  output logic             byte_valid_o,
  output logic [7:0]       byte_o,
  output logic [2:0]       byte_type_o,
  output logic             byte_last_o,
  input  logic             byte_ready_i,
  output logic             msg_done_o,
  output logic [CNT_W-1:0] msg_len_o,
  output logic             tag_fail_o
);
  localparam pack_state_t END_ST = STATUS_EN ? STATUS : END;
  pack_state_t      state, state_nxt;
  logic [31:0]      word;
  logic [2:0]       typ;
  logic [3:0]       mask;
  logic             end_f;
  logic             auth_seen, tag_seen, done_seen;
  logic             auth_nxt, tag_nxt, done_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       lane;
  logic             one_left, beat, hs, last_unused;
  ascon_byte_pick u_pick (.mask(mask), .lane(lane), .one_left(one_left));
  // bd_last_i is informational only; message boundaries come from auth/done
  assign last_unused  = bd_last_i;
  assign bdo_ready_o  = state == IDLE;
  assign byte_valid_o = state == EMIT || state == STATUS;
  assign byte_o       = state == EMIT ? word[{lane, 3'b000} +: 8] :
                        state == STATUS ? status_byte(auth_seen, tag_seen, done_seen) : 8'h00;
  assign byte_type_o  = state == EMIT ? typ : 3'd0;
  assign byte_last_o  = state == STATUS || (state == EMIT && !STATUS_EN && end_f && one_left);
  assign msg_done_o   = state == END;
  assign beat         = (bd_valid_i | auth_valid_i | done_i) & bdo_ready_o;
  assign hs           = byte_valid_o & byte_ready_i;
  assign auth_nxt     = auth_seen | (beat & auth_valid_i);
  assign tag_nxt      = tag_seen | (beat & auth_valid_i & tag_match_i);
  assign done_nxt     = done_seen | (beat & done_i);
  assign cnt_nxt      = (state == EMIT && hs && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = (bd_valid_i && bd_vld_byte_i != 4'd0) ? EMIT :
                                     (auth_valid_i | done_i) ? END_ST : IDLE;
      EMIT:    if (hs && one_left) state_nxt = end_f ? END_ST : IDLE;
      STATUS:  if (hs) state_nxt = END;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      word       <= '0;
      typ        <= '0;
      mask       <= '0;
      end_f      <= 1'b0;
      auth_seen  <= 1'b0;
      tag_seen   <= 1'b0;
      done_seen  <= 1'b0;
      cnt        <= '0;
      msg_len_o  <= '0;
      tag_fail_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        word  <= bd_i;
        typ   <= bd_type_i;
        mask  <= bd_valid_i ? bd_vld_byte_i : 4'd0;
        end_f <= auth_valid_i | done_i;
      end else if (state == EMIT && hs) begin
        mask <= mask & ~(4'b0001 << lane);
      end
      cnt       <= state == END ? '0 : cnt_nxt;
      auth_seen <= state == END ? 1'b0 : auth_nxt;
      tag_seen  <= state == END ? 1'b0 : tag_nxt;
      done_seen <= state == END ? 1'b0 : done_nxt;
      // capture with this cycle's beat/handshake folded in, since END may be entered directly
      if (state_nxt == END) begin
        msg_len_o  <= cnt_nxt;
        tag_fail_o <= auth_nxt & ~tag_nxt;
      end
    end
  end
endmodule
